// File: rtl/fetch_queue_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rv32_fetch_pkg
// Purpose  : Shared types and constants for the RV32I fetch front end.
// Contents : FETCH_XLEN, fetch_entry_t {pc, instr}, NOP_INSTR,
//            DEFAULT_RESET_PC
// Revision : 1.0 - initial release
// ============================================================================
package rv32_fetch_pkg;

  localparam int FETCH_XLEN = 32;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  localparam logic [FETCH_XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : rv32_fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : fetch_queue_unit_if
// Purpose   : Groups the instruction-memory request/response channels and
//             the decode-side instruction channel of the fetch unit.
// Modports  : master - fetch unit side (drives requests and instructions)
//             slave  - environment side (memory + decode)
// Revision  : 1.0 - initial release
// ============================================================================
interface fetch_queue_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface : fetch_queue_unit_if
`default_nettype wire

// File: rtl/fetch_queue_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Synchronous FIFO with synchronous flush and a registered head
//            output (dout always shows the oldest entry while count != 0).
// Ports    : clk, rst    - clock, synchronous active-high reset
//            flush       - empty the FIFO on the next edge
//            push, din   - write request / data (ignored when full w/o pop)
//            pop         - remove head (ignored when empty)
//            dout        - registered head entry
//            count       - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] din,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] dout,
  output logic      [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             w_do_pop;
  logic             w_do_push;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    else                     return p + 1'b1;
  endfunction

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !rst && !flush) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      // Head register: load the incoming word when it becomes the head,
      // otherwise advance to the second-oldest stored entry on a pop.
      if (r_count == '0) begin
        if (w_do_push) r_dout <= din;
      end else if (w_do_pop) begin
        if (r_count > CW'(1))  r_dout <= r_mem[next_ptr(r_rd_ptr)];
        else if (w_do_push)    r_dout <= din;
      end
    end
  end

  assign dout  = r_dout;
  assign count = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : RV32I instruction-fetch front end. Issues in-order word fetches,
//            tracks request PCs, buffers returned words in a DEPTH-entry
//            queue for decode and handles redirects by flushing and dropping
//            in-flight responses.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            redirect_valid/pc   - load a new fetch PC (bits [1:0] ignored)
//            bus (master)        - imem request/response, decode channel
//            outstanding         - requests currently in flight
// Revision : 1.0 - initial release
// ============================================================================
import rv32_fetch_pkg::*;

module fetch_queue_unit #(
  parameter int              XLEN            = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  localparam int             OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            redirect_valid,
  input  wire logic [XLEN-1:0] redirect_pc,
  fetch_queue_unit_if.master   bus,
  output logic      [OW-1:0]   outstanding
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int SW  = $clog2(DEPTH + MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_started;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_drop_cnt;

  logic [XLEN-1:0] w_track_pc;
  logic [OW-1:0]   w_track_count;
  logic [QCW-1:0]  w_q_count;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head_entry;
  logic [SW-1:0]   w_used;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_rsp_drop;
  logic            w_pop;
  logic [OW-1:0]   w_out_next;

  // Every in-flight request already owns a queue slot. Responses write the
  // queue directly, so there is no extra pending-response stage to reserve.
  assign w_used = SW'(r_outstanding) + SW'(w_q_count);

  // r_started holds issue off for the first cycle out of reset.
  assign w_req_valid = r_started && !rst && !redirect_valid
                    && (w_used < SW'(DEPTH))
                    && (r_outstanding < OW'(MAX_OUTSTANDING));
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;

  // A response without a tracked PC would be a memory protocol error; the
  // track-count term keeps such a word out of the queue.
  assign w_rsp_keep = bus.imem_rsp_valid && (r_drop_cnt == '0)
                   && (w_track_count != '0);
  assign w_rsp_drop = bus.imem_rsp_valid && (r_drop_cnt != '0);

  assign w_pop      = bus.inst_valid && bus.inst_ready;
  assign w_out_next = r_outstanding + OW'(w_req_fire) - OW'(bus.imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_started     <= 1'b0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_started     <= 1'b1;
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & ~XLEN'(3);
        // Everything still in flight after this edge belongs to the old path.
        r_drop_cnt <= w_out_next;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  // PCs of issued-but-unreturned requests, in issue order.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_track (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (w_req_fire),
    .din   (r_fetch_pc),
    .pop   (w_rsp_keep),
    .dout  (w_track_pc),
    .count (w_track_count)
  );

  assign w_push_entry.pc    = w_track_pc;
  assign w_push_entry.instr = bus.imem_rsp_data;

  // Instruction queue; the head register drives decode directly.
  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (w_rsp_keep),
    .din   (w_push_entry),
    .pop   (w_pop),
    .dout  (w_head_entry),
    .count (w_q_count)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = (w_q_count != '0);
  assign bus.inst_data      = w_head_entry.instr;
  assign bus.inst_pc        = w_head_entry.pc;
  assign outstanding        = r_outstanding;

endmodule : fetch_queue_unit
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Purpose  : Self-checking bench for fetch_queue_unit. A memory model serves
//            requests in order with random latency; a scoreboard holds the
//            program-order instruction stream expected by decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;
  import rv32_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [1:0]  outstanding;

  fetch_queue_unit_if #(.XLEN(32)) bus();

  fetch_queue_unit #(
    .XLEN            (32),
    .RESET_PC        (DEFAULT_RESET_PC),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master),
    .outstanding    (outstanding)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: any fixed function of the address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ NOP_INSTR;
  endfunction

  // ---------------- scoreboard: program-order stream ----------------
  fetch_entry_t sb[$];
  logic [31:0]  gen_pc = DEFAULT_RESET_PC;

  function automatic void topup();
    fetch_entry_t e;
    while (sb.size() < 16) begin
      e.pc    = gen_pc;
      e.instr = imem_word(gen_pc);
      sb.push_back(e);
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  function automatic void restart_stream(input logic [31:0] pc);
    sb.delete();
    gen_pc = pc & ~32'd3;
    topup();
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  mreq_t       mreq;
  int          ready_pct = 100;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          cyc = 0;
  logic        presented = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    presented = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = imem_word(mq[0].addr);
      void'(mq.pop_front());
      presented = 1'b1;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    #2;
    if (rst) begin
      mq.delete();
      bus.imem_rsp_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("outstanding_count", 32'(outstanding), 32'(mq.size()) + 32'(presented));
      if (prev_stall && !redirect_valid) begin
        check("req_valid_held", 32'(bus.imem_req_valid), 32'd1);
        check("req_addr_held", bus.imem_req_addr, prev_addr);
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        mreq.addr = bus.imem_req_addr;
        mreq.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
        mq.push_back(mreq);
      end
      prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
      prev_addr  = bus.imem_req_addr;
    end
    cyc++;
  end

  // ---------------- monitor ----------------
  fetch_entry_t mon_e;

  always @(negedge clk) begin
    #3;
    if (!rst && !redirect_valid && bus.inst_valid && bus.inst_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got pc %h with no expected entry", bus.inst_pc);
      end else begin
        mon_e = sb.pop_front();
        check("inst_pc", bus.inst_pc, mon_e.pc);
        check("inst_data", bus.inst_data, mon_e.instr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    topup();
  endtask

  task automatic do_reset(input int n);
    tick();
    rst = 1'b1;
    redirect_valid = 1'b0;
    restart_stream(DEFAULT_RESET_PC);
    repeat (n - 1) tick();
    tick();
    rst = 1'b0;
  endtask

  // Called at the start of a cycle; returns at the start of the next one.
  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    restart_stream(pc);
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int first;
  int w;

  initial begin
    bus.inst_ready = 1'b1;

    // Reset state and first-fetch latency.
    do_reset(3);
    first = -1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k == 0) begin
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_inst_data", bus.inst_data, 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
      end
      if (bus.inst_valid && first < 0) begin
        first = k;
        check("first_inst_pc", bus.inst_pc, DEFAULT_RESET_PC);
      end
      tick();
    end
    check("first_valid_latency", 32'(first), 32'd3);
    repeat (10) tick();

    // Stall: queue fills to DEPTH, then issue stops.
    bus.inst_ready = 1'b0;
    do_reset(2);
    repeat (20) tick();
    #1;
    check("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
    check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("stall_outstanding", 32'(outstanding), 32'd0);
    check("stall_head_pc", bus.inst_pc, 32'd0);
    check("stall_head_data", bus.inst_data, imem_word(32'd0));
    tick();
    bus.inst_ready = 1'b1;
    repeat (20) tick();

    // Redirect while two requests are in flight.
    lat_lo = 3;
    lat_hi = 3;
    do_reset(2);
    w = 0;
    while (outstanding != 2'd2 && w < 50) begin
      tick();
      w++;
    end
    check("two_outstanding", 32'(outstanding), 32'd2);
    do_redirect(32'h100);
    #1;
    check("redirect_flush_valid", 32'(bus.inst_valid), 32'd0);
    w = 0;
    while (!bus.inst_valid && w < 40) begin
      tick();
      #1;
      w++;
    end
    check("redirect_first_pc", bus.inst_pc, 32'h100);
    repeat (20) tick();

    // Misaligned redirect target.
    lat_lo = 1;
    lat_hi = 1;
    tick();
    do_redirect(32'h203);
    #1;
    w = 0;
    while (!bus.imem_req_valid && w < 20) begin
      tick();
      #1;
      w++;
    end
    check("aligned_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("aligned_req_addr", bus.imem_req_addr, 32'h200);
    repeat (10) tick();

    // Wrap past the top of the address space.
    do_redirect(32'hFFFF_FFF8);
    #1;
    w = 0;
    while (!bus.inst_valid && w < 20) begin
      tick();
      #1;
      w++;
    end
    check("wrap_first_pc", bus.inst_pc, 32'hFFFF_FFF8);
    repeat (15) tick();

    // Random traffic with random redirects and one mid-stream reset.
    ready_pct = 50;
    lat_lo = 1;
    lat_hi = 3;
    for (int i = 0; i < 1500; i++) begin
      tick();
      bus.inst_ready = ($urandom_range(3) != 0);
      if (i == 700) begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        restart_stream(DEFAULT_RESET_PC);
      end else begin
        rst = 1'b0;
        if (i != 701 && $urandom_range(99) < 3) begin
          redirect_valid = 1'b1;
          redirect_pc    = $urandom;
          restart_stream(redirect_pc);
        end else begin
          redirect_valid = 1'b0;
        end
        if (i == 701) begin
          #1;
          check("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
          check("midrst_outstanding", 32'(outstanding), 32'd0);
          check("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
          check("midrst_inst_pc", bus.inst_pc, 32'd0);
          check("midrst_fetch_addr", bus.imem_req_addr, DEFAULT_RESET_PC);
        end
      end
    end
    tick();
    redirect_valid = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_queue_unit
`default_nettype wire
